// File: rtl/dac_feeder.sv
// dac_feeder: PCM sample FIFO feeding an offset-binary sigma-delta DAC once per oversampled period.
// Define DAC_FEEDER_INTERP_EN to ramp linearly between samples instead of zero-order hold.
module dac_feeder #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DIV_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [15:0]            s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [3:0]             vol_shift,
    output logic [15:0]            dac_din,
    output logic                   sample_tick,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = DIV_LOG2;

    logic [15:0]        mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               ready_q, ready_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               underrun_q, underrun_d;
    logic signed [15:0] cur_q, cur_d;
    logic signed [15:0] prev_q, prev_d;
    logic [15:0]        dac_q, dac_d;
    logic               push, pop;
    logic signed [15:0] out_sample;
    logic signed [15:0] scaled;

    // FIFO bookkeeping, period counter and sample pipeline
    always_comb begin
        push       = s_valid && ready_q;
        pop        = tick_q && enable && (level_q != '0);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d    = level_q + LW'(push) - LW'(pop);
        ready_d    = (level_d != LW'(DEPTH));
        cnt_d      = enable ? cnt_q + CW'(1) : '0;
        tick_d     = enable && (cnt_d == {CW{1'b1}});
        // the tick cycle sees the occupancy that is being registered now
        underrun_d = tick_d && (level_d == '0);
        cur_d      = cur_q;
        prev_d     = prev_q;
        if (!enable) begin
            cur_d  = '0;
            prev_d = '0;
        end else if (tick_q) begin
            prev_d = cur_q;
            if (pop) begin
                cur_d = mem_q[rd_ptr_q];
            end
        end
    end

`ifdef DAC_FEEDER_INTERP_EN
    localparam int unsigned AccW = 17 + DIV_LOG2;

    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [16:0]     delta;

    // accumulator steps by (cur - prev) so it lands on cur in the last cycle of the period
    always_comb begin
        delta = $signed({cur_d[15], cur_d}) - $signed({prev_d[15], prev_d});
        acc_d = acc_q + AccW'(delta);
        if (!enable) begin
            acc_d = '0;
        end else if (tick_q) begin
            acc_d = (AccW'(prev_d) <<< DIV_LOG2) + AccW'(delta);
        end
        out_sample = 16'(acc_d >>> DIV_LOG2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    always_comb begin
        out_sample = cur_d;
    end
`endif

    // volume attenuation and conversion to offset binary
    always_comb begin
        scaled = out_sample >>> vol_shift;
        dac_d  = {~scaled[15], scaled[14:0]};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b0;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            cur_q      <= '0;
            prev_q     <= '0;
            dac_q      <= 16'h8000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            dac_q      <= dac_d;
        end
    end

    assign s_ready     = ready_q;
    assign dac_din     = dac_q;
    assign sample_tick = tick_q;
    assign underrun    = underrun_q;
    assign level       = level_q;

endmodule

// File: doc/dac_feeder.md
DAC_FEEDER -- requirements
Module: dac_feeder

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in samples; power of two, 2..16.
REQ-002 Parameter DIV_LOG2, default 10, log2 of clocks per output sample period (1024x oversampling).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  run; low = idle, midscale output.
REQ-006 s_data  input  16  signed two's-complement PCM sample.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  block can accept a sample.
REQ-009 vol_shift  input  4  attenuation, arithmetic right shift by 0..15.
REQ-010 dac_din  output  16  offset-binary code to the sigma-delta DAC, registered.
REQ-011 sample_tick  output  1  one-cycle pulse at each sample-period boundary.
REQ-012 underrun  output  1  one-cycle pulse when a tick finds the FIFO empty.
REQ-013 level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 FIFO SHALL accept a sample when s_valid && s_ready; s_ready SHALL equal (level != DEPTH), depending only on registered state.
REQ-015 Push and pop in the same cycle SHALL both happen; level SHALL stay unchanged.
REQ-016 With enable high, period counter SHALL count 0..2^DIV_LOG2-1 and wrap; sample_tick SHALL be high in the cycle the counter equals 2^DIV_LOG2-1.
REQ-017 On a tick with level>0, the FIFO head SHALL be popped into the current-sample register (cur); prev SHALL take the old cur.
REQ-018 On a tick with level==0, cur SHALL be held, prev SHALL take cur, and underrun SHALL pulse for that cycle.
REQ-019 Scaled value SHALL be cur >>> vol_shift (sign-extending); dac_din SHALL be scaled value with bit 15 inverted (signed 0 -> 16'h8000, 16'h7FFF -> 16'hFFFF, 16'h8000 -> 16'h0000).
REQ-020 Without interpolation, dac_din SHALL reflect a popped sample in the cycle after the tick (1-cycle latency) and hold for the whole period.
REQ-021 vol_shift changes SHALL take effect on dac_din in the next cycle, not at a tick.
REQ-022 With enable low: counter held at 0, no ticks, no pops, no underrun, pushes still accepted, dac_din=16'h8000, cur=prev=0.
REQ-023 On enable rising, the first tick SHALL occur 2^DIV_LOG2 cycles later.

Reset
REQ-024 While rst_n low: FIFO emptied (level=0), counter=0, cur=prev=0, s_ready=0, sample_tick=0, underrun=0, dac_din=16'h8000.
REQ-025 s_ready SHALL rise the first clock edge after rst_n deasserts; reset mid-operation SHALL discard all buffered samples.

Configuration
REQ-026 Macro DAC_FEEDER_INTERP_EN defined: output SHALL ramp linearly from prev to cur over each period via accumulator of 17+DIV_LOG2 bits, loaded with prev<<DIV_LOG2 at tick and incremented by (cur-prev) each cycle; dac_din = offset-binary of (acc>>>DIV_LOG2)>>>vol_shift, reaching cur exactly at the final cycle of the period.
REQ-027 Macro undefined: zero-order hold per REQ-020; no accumulator logic SHALL be synthesized.

Verification (bench with DEPTH=4, DIV_LOG2=2)
REQ-028 Reset, enable=1, no input -> dac_din=16'h8000, sample_tick every 4 cycles, underrun on each tick.
REQ-029 Push 16'h7FFF, 16'h8000, 16'h0000, vol_shift=0 -> dac_din 16'hFFFF, 16'h0000, 16'h8000 on successive periods, each 1 cycle after its tick (ZOH build).
REQ-030 Push 5 samples back-to-back with enable=0 -> s_ready low after 4th, level=4, 5th held until enable=1 and first pop.
REQ-031 Sample 16'h4000, vol_shift=2 -> dac_din=16'h9000; sample 16'hC000, vol_shift=15 -> dac_din=16'h7FFF.
REQ-032 INTERP_EN build, samples 0 then 16'h0400 -> dac_din 16'h8100, 16'h8200, 16'h8300, 16'h8400 across the period.
REQ-033 rst_n low mid-period with level=3 -> level=0, dac_din=16'h8000 immediately, no pops after release until new pushes.
